controle_excecao: RTL
=====================

CONTROLE_EXCECAO -- requirements
Module: controle_excecao

Interface
REQ-001 SHALL have parameter LATENCIA_MEM, default 2: wait cycles from mem_read assertion until dado_mem is valid (legal 1..7).
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port causa_opcode, input, 1 bit: one-cycle pulse for an invalid-opcode exception.
REQ-005 SHALL have port causa_overflow, input, 1 bit: one-cycle pulse for an arithmetic-overflow exception.
REQ-006 SHALL have port causa_divzero, input, 1 bit: one-cycle pulse for a divide-by-zero exception.
REQ-007 SHALL have port pc_atual, input, 32 bits: PC of the faulting instruction, held stable by the datapath while ocupado=1.
REQ-008 SHALL have port dado_mem, input, 8 bits: byte read from the handler-vector table.
REQ-009 SHALL have port controle, output, 2 bits: vector-address select (00→253, 01→254, 10→255); 11 is never driven.
REQ-010 SHALL have port mem_read, output, 1 bit: memory read strobe for the vector fetch.
REQ-011 SHALL have port pc_write, output, 1 bit: one-cycle strobe loading novo_pc into PC.
REQ-012 SHALL have port novo_pc, output, 32 bits: handler address, {24'b0, dado_mem}.
REQ-013 SHALL have port epc, output, 32 bits: saved return address.
REQ-014 SHALL have port causa, output, 2 bits: code of the exception being served or last served.
REQ-015 SHALL have port ocupado, output, 1 bit: high in every non-OCIOSO state; stalls the datapath.

Function
REQ-016 SHALL implement FSM states OCIOSO, SALVA_EPC, LE_MEM, CARREGA_PC.
REQ-017 SHALL OR each causa_* pulse into a sticky pendente[2:0] bit on every cycle, in any state.
REQ-018 SHALL, in OCIOSO with any pendente bit or pulse set, move to SALVA_EPC the next cycle, choosing priority opcode > overflow > divzero.
REQ-019 SHALL, on that transition, clear only the selected pendente bit and register controle and causa from the selection.
REQ-020 SHALL, in SALVA_EPC (1 cycle), load epc from pc_atual and proceed to LE_MEM.
REQ-021 SHALL hold mem_read=1 in LE_MEM for exactly LATENCIA_MEM cycles using a 3-bit down-counter, then go to CARREGA_PC.
REQ-022 SHALL, in CARREGA_PC (1 cycle), pulse pc_write=1 with novo_pc={24'b0, dado_mem sampled on the last LE_MEM cycle}, then return to OCIOSO.
REQ-023 SHALL keep controle stable from SALVA_EPC through CARREGA_PC; total service latency = LATENCIA_MEM+2 cycles after acceptance.
REQ-024 SHALL serve remaining pendente bits back-to-back; OCIOSO lasts one cycle between services.
REQ-025 SHALL treat a pulse for a cause already pending as a single event (no counting).

Reset
REQ-026 SHALL, on reset=0 in any state (including mid-LE_MEM), immediately force OCIOSO and zero controle, causa, epc, novo_pc, mem_read, pc_write, ocupado, pendente and the counter.

Configuration
REQ-027 SHALL, with EXCECAO_DIVZERO_EN defined, implement the divide-by-zero path as above.
REQ-028 SHALL, without EXCECAO_DIVZERO_EN, ignore causa_divzero, tie pendente[2] to 0 and never drive controle=10.

Structure
REQ-029 SHALL place the state enum, select codes (SEL_OPCODE=00, SEL_OVERFLOW=01, SEL_DIVZERO=10) and causa codes in shared package pacote_excecao.
REQ-030 SHALL implement priority selection in sub-module codificador_prioridade (3-bit pendente → 2-bit select + valid).

Verification
REQ-031 SHALL cover: causa_overflow pulse, LATENCIA_MEM=2, dado_mem=0xFE, pc_atual=0x40 → controle=01, epc=0x40, mem_read for 2 cycles, pc_write with novo_pc=0x000000FE 4 cycles after acceptance.
REQ-032 SHALL cover: causa_opcode and causa_divzero pulses in the same cycle → opcode served first (controle=00, causa=opcode), then divzero (controle=10) after one OCIOSO cycle.
REQ-033 SHALL cover: causa_overflow pulse during LE_MEM of an opcode service → overflow served immediately after, ocupado low for exactly one cycle between services.
REQ-034 SHALL cover: reset=0 asserted mid-LE_MEM with a pending bit set → all outputs 0 asynchronously, no pc_write, pending exception lost.
REQ-035 SHALL cover: EXCECAO_DIVZERO_EN undefined, causa_divzero pulse → ocupado stays 0, controle never 10.

Source files
------------

// File: rtl/pacote_excecao.sv
// Shared types and codes for the exception controller.
package pacote_excecao;

  // Exception-service FSM states
  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    SALVA_EPC  = 2'd1,
    LE_MEM     = 2'd2,
    CARREGA_PC = 2'd3
  } estado_t;

  // Vector-address select codes (00->253, 01->254, 10->255)
  localparam logic [1:0] SEL_OPCODE   = 2'b00;
  localparam logic [1:0] SEL_OVERFLOW = 2'b01;
  localparam logic [1:0] SEL_DIVZERO  = 2'b10;

  // Cause codes reported on the causa output
  localparam logic [1:0] CAUSA_OPCODE   = 2'b00;
  localparam logic [1:0] CAUSA_OVERFLOW = 2'b01;
  localparam logic [1:0] CAUSA_DIVZERO  = 2'b10;

  // One-hot pendente mask for a given select code
  function automatic logic [2:0] mascara_sel(input logic [1:0] sel);
    return 3'b001 << sel;
  endfunction

  // Cause code corresponding to a select code
  function automatic logic [1:0] sel_para_causa(input logic [1:0] sel);
    logic [1:0] causa_v;
    unique case (sel)
      SEL_OVERFLOW: causa_v = CAUSA_OVERFLOW;
      SEL_DIVZERO:  causa_v = CAUSA_DIVZERO;
      default:      causa_v = CAUSA_OPCODE;
    endcase
    return causa_v;
  endfunction

endpackage

// File: rtl/codificador_prioridade.sv
// Fixed-priority encoder: opcode (bit 0) > overflow (bit 1) > divzero (bit 2).
module codificador_prioridade
  import pacote_excecao::*;
(
  input  logic [2:0] i_pendente,
  output logic [1:0] o_sel,
  output logic       o_valido
);

  // Pick the highest-priority pending cause
  always_comb begin
    o_valido = |i_pendente;
    o_sel    = SEL_OPCODE;
    if (i_pendente[0]) begin
      o_sel = SEL_OPCODE;
    end else if (i_pendente[1]) begin
      o_sel = SEL_OVERFLOW;
    end else if (i_pendente[2]) begin
      o_sel = SEL_DIVZERO;
    end
  end

endmodule

// File: rtl/controle_excecao.sv
// Exception controller: latches cause pulses, saves EPC, fetches the handler
// vector byte from memory and loads it into the PC.
// Optional feature: define EXCECAO_DIVZERO_EN to enable the divide-by-zero cause.
module controle_excecao
  import pacote_excecao::*;
#(
  parameter int unsigned LATENCIA_MEM = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        causa_opcode,
  input  logic        causa_overflow,
  input  logic        causa_divzero,
  input  logic [31:0] pc_atual,
  input  logic [7:0]  dado_mem,
  output logic [1:0]  controle,
  output logic        mem_read,
  output logic        pc_write,
  output logic [31:0] novo_pc,
  output logic [31:0] epc,
  output logic [1:0]  causa,
  output logic        ocupado
);

  localparam logic [2:0] LatenciaCarga = 3'(LATENCIA_MEM);

  estado_t     r_estado;
  logic [2:0]  r_pendente;
  logic [2:0]  r_contador;
  logic [1:0]  r_controle;
  logic [1:0]  r_causa;
  logic [31:0] r_epc;
  logic [31:0] r_novo_pc;
  logic        r_mem_read;
  logic        r_pc_write;
  logic        r_ocupado;

  logic [2:0]  w_pulsos;
  logic [2:0]  w_candidatos;
  logic [1:0]  w_sel;
  logic        w_valido;

`ifdef EXCECAO_DIVZERO_EN
  assign w_pulsos = {causa_divzero, causa_overflow, causa_opcode};
`else
  // Divide-by-zero path removed: its pending bit can never be set
  logic w_unused_divzero;
  assign w_unused_divzero = causa_divzero;
  assign w_pulsos = {1'b0, causa_overflow, causa_opcode};
`endif

  // Pulses arriving this cycle compete for acceptance alongside stored ones
  assign w_candidatos = r_pendente | w_pulsos;

  codificador_prioridade u_codificador (
    .i_pendente (w_candidatos),
    .o_sel      (w_sel),
    .o_valido   (w_valido)
  );

  // Service FSM with registered outputs and sticky pending causes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_pendente <= 3'b000;
      r_contador <= 3'd0;
      r_controle <= 2'b00;
      r_causa    <= 2'b00;
      r_epc      <= 32'h0;
      r_novo_pc  <= 32'h0;
      r_mem_read <= 1'b0;
      r_pc_write <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_pendente <= w_candidatos;
      r_pc_write <= 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          if (w_valido) begin
            r_pendente <= w_candidatos & ~mascara_sel(w_sel);
            r_controle <= w_sel;
            r_causa    <= sel_para_causa(w_sel);
            r_ocupado  <= 1'b1;
            r_estado   <= SALVA_EPC;
          end
        end
        SALVA_EPC: begin
          r_epc      <= pc_atual;
          r_contador <= LatenciaCarga;
          r_mem_read <= 1'b1;
          r_estado   <= LE_MEM;
        end
        LE_MEM: begin
          if (r_contador == 3'd1) begin
            // Last wait cycle: dado_mem is valid now
            r_novo_pc  <= {24'h0, dado_mem};
            r_mem_read <= 1'b0;
            r_pc_write <= 1'b1;
            r_contador <= 3'd0;
            r_estado   <= CARREGA_PC;
          end else begin
            r_contador <= r_contador - 3'd1;
          end
        end
        CARREGA_PC: begin
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  assign controle = r_controle;
  assign mem_read = r_mem_read;
  assign pc_write = r_pc_write;
  assign novo_pc  = r_novo_pc;
  assign epc      = r_epc;
  assign causa    = r_causa;
  assign ocupado  = r_ocupado;

endmodule
